// File: rtl/hht_spmv_row_mac.sv
// Per-row multiply-accumulate for the CSR SpMV path: input pair FIFO, product stage,
// accumulate stage, single-entry result register. Optional saturation: HHT_MAC_SAT_EN.
module hht_spmv_row_mac #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ACC_W      = 64,
    parameter int unsigned NUM_ROWS   = 16,
    parameter int unsigned ROW_W      = 5,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_mat,
    input  logic [DATA_W-1:0] in_vec,
    input  logic              in_last,
    input  logic              in_empty_row,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic [ROW_W-1:0]  res_row,
    output logic              res_mlast,
    output logic              busy,
    output logic              ovf
);

    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned ProdW = 2 * DATA_W;
    localparam int unsigned EntW  = ProdW + 2;

    logic [EntW-1:0]  fifo_q [FIFO_DEPTH];
    logic [PtrW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             p_valid_q, p_valid_d, p_final_q, p_final_d;
    logic [ProdW-1:0] p_prod_q, p_prod_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             row_act_q, row_act_d;
    logic             res_valid_q, res_valid_d;
    logic [ACC_W-1:0] res_data_q, res_data_d;
    logic [ROW_W-1:0] res_row_q, res_row_d;
    logic             ovf_q, ovf_d;

    logic              fifo_empty, fifo_full, push, pop, a_stall, a_fire, carry;
    logic [EntW-1:0]   head;
    logic              head_last, head_empty;
    logic [DATA_W-1:0] head_mat, head_vec;
    logic [ProdW-1:0]  head_prod;
    logic [ACC_W:0]    sum;
    logic [ACC_W-1:0]  acc_next;
    logic [ROW_W-1:0]  row_inc;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                        (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign push       = in_valid && !fifo_full;

    assign head = fifo_q[rd_ptr_q[PtrW-1:0]];
    assign {head_last, head_empty, head_mat, head_vec} = head;
    assign head_prod = head_empty ? '0 : ProdW'(head_mat) * ProdW'(head_vec);

    // Only a row-final pair needs the output register, so only it can stall.
    assign a_stall = p_valid_q && p_final_q && res_valid_q && !res_ready;
    assign a_fire  = p_valid_q && !a_stall;
    assign pop     = !fifo_empty && (!p_valid_q || a_fire);

    assign sum   = {1'b0, acc_q} + {1'b0, ACC_W'(p_prod_q)};
    assign carry = sum[ACC_W];

    always_comb begin
        acc_next = sum[ACC_W-1:0];
`ifdef HHT_MAC_SAT_EN
        if (carry) begin
            acc_next = '1;
        end
`endif
    end

    assign row_inc = (row_q == ROW_W'(NUM_ROWS - 1)) ? '0 : row_q + ROW_W'(1);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        p_valid_d   = p_valid_q;
        p_final_d   = p_final_q;
        p_prod_d    = p_prod_q;
        acc_d       = acc_q;
        row_d       = row_q;
        row_act_d   = row_act_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_row_d   = res_row_q;
        ovf_d       = ovf_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            p_valid_d = 1'b1;
            p_final_d = head_last || head_empty;
            p_prod_d  = head_prod;
        end else if (a_fire) begin
            p_valid_d = 1'b0;
        end

        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
        if (a_fire) begin
            if (carry) begin
                ovf_d = 1'b1;
            end
            if (p_final_q) begin
                res_valid_d = 1'b1;
                res_data_d  = acc_next;
                res_row_d   = row_q;
                acc_d       = '0;
                row_d       = row_inc;
                row_act_d   = 1'b0;
            end else begin
                acc_d     = acc_next;
                row_act_d = 1'b1;
            end
        end

        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            p_valid_d   = 1'b0;
            p_final_d   = 1'b0;
            p_prod_d    = '0;
            acc_d       = '0;
            row_d       = '0;
            row_act_d   = 1'b0;
            res_valid_d = 1'b0;
            res_data_d  = '0;
            res_row_d   = '0;
            ovf_d       = 1'b0;
        end
    end

    // Storage needs no reset: pointers alone define occupancy.
    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_q[wr_ptr_q[PtrW-1:0]] <= {in_last, in_empty_row, in_mat, in_vec};
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            p_valid_q   <= 1'b0;
            p_final_q   <= 1'b0;
            p_prod_q    <= '0;
            acc_q       <= '0;
            row_q       <= '0;
            row_act_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_row_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            p_valid_q   <= p_valid_d;
            p_final_q   <= p_final_d;
            p_prod_q    <= p_prod_d;
            acc_q       <= acc_d;
            row_q       <= row_d;
            row_act_q   <= row_act_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_row_q   <= res_row_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready  = !fifo_full;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_row   = res_row_q;
    assign res_mlast = res_valid_q && (res_row_q == ROW_W'(NUM_ROWS - 1));
    assign ovf       = ovf_q;
    assign busy      = !fifo_empty || p_valid_q || (acc_q != '0) || row_act_q || res_valid_q;

endmodule
